// File: rtl/hamming_secded_dec.sv
// rtl/hamming_secded_dec.sv - Extended Hamming(8,4) SECDED decoder, two-stage elastic pipeline
// Optional saturating error counters are enabled by defining HAMMING_ERR_CNT_EN.
module hamming_secded_dec #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_sec,
    output logic             out_ded,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic       s1_valid;
    logic [7:0] s1_cw;
    logic [2:0] s1_syn;
    logic       s1_par;

    logic       s2_load;
    logic       accept;
    logic [2:0] syn_in;
    logic       par_in;

    logic [7:0] fix_cw;
    logic [3:0] cls_data;
    logic       cls_sec;
    logic       cls_ded;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    // Syndrome bit k covers every Hamming position whose index has bit k set.
    always_comb begin
        syn_in[0] = in_cw[1] ^ in_cw[3] ^ in_cw[5] ^ in_cw[7];
        syn_in[1] = in_cw[2] ^ in_cw[3] ^ in_cw[6] ^ in_cw[7];
        syn_in[2] = in_cw[4] ^ in_cw[5] ^ in_cw[6] ^ in_cw[7];
        par_in    = ^in_cw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else begin
            s1_valid <= accept || (s1_valid && !s2_load);
            if (accept) begin
                s1_cw  <= in_cw;
                s1_syn <= syn_in;
                s1_par <= par_in;
            end
        end
    end

    // Odd overall parity means a single error; the syndrome points at it unless it is bit 0.
    always_comb begin
        fix_cw  = s1_cw;
        cls_sec = 1'b0;
        cls_ded = 1'b0;
        if (s1_par) begin
            cls_sec = 1'b1;
            if (s1_syn != 3'd0) begin
                fix_cw = s1_cw ^ (8'd1 << s1_syn);
            end
        end else if (s1_syn != 3'd0) begin
            cls_ded = 1'b1;
        end
        cls_data = {fix_cw[7], fix_cw[6], fix_cw[5], fix_cw[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            out_sec      <= 1'b0;
            out_ded      <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= cls_data;
                out_syndrome <= s1_syn;
                out_sec      <= cls_sec;
                out_ded      <= cls_ded;
            end
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    logic out_hs;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (out_sec && (corr_cnt != {CNT_W{1'b1}})) begin
                corr_cnt <= corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (out_ded && (uncorr_cnt != {CNT_W{1'b1}})) begin
                uncorr_cnt <= uncorr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_dec.sv
// tb/tb_hamming_secded_dec.sv - scoreboard bench for hamming_secded_dec
module tb_hamming_secded_dec;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syn;
        logic       sec;
        logic       ded;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_cw;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic       out_sec;
    logic       out_ded;
    logic       cnt_clr;
    logic [7:0] corr_cnt;
    logic [7:0] uncorr_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   m_corr = 0;
    int   m_uncorr = 0;

    logic [7:0] v_cw[9];
    exp_t       v_exp[9];

    hamming_secded_dec #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome),
        .out_sec(out_sec), .out_ded(out_ded),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int m);
`ifdef HAMMING_ERR_CNT_EN
        return 32'(m);
`else
        return (m > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Monitor: pops the scoreboard on every output handshake and models the counters.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", {23'd0, out_data, out_syndrome, out_sec, out_ded}, {23'd0, e});
                    if (!cnt_clr) begin
                        if (e.sec && m_corr < 255) m_corr++;
                        if (e.ded && m_uncorr < 255) m_uncorr++;
                    end
                end
            end
            if (cnt_clr) begin
                m_corr   = 0;
                m_uncorr = 0;
            end
        end
    end

    // Presents one word at posedge+1; returns at posedge+1 after its accept edge.
    task automatic send(input logic [7:0] cw, input exp_t e, output int stalls);
        bit ok = 0;
        stalls   = 0;
        in_valid = 1'b1;
        in_cw    = cw;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            stalls++;
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        else sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_cw    = 8'h00;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_corr"}, 32'(corr_cnt), exp_cnt(m_corr));
        check({tag, "_uncorr"}, 32'(uncorr_cnt), exp_cnt(m_uncorr));
    endtask

    initial begin
        int st;
        int tot;
        v_cw[0] = 8'hAA; v_exp[0] = '{4'hB, 3'd0, 1'b0, 1'b0};
        v_cw[1] = 8'h8A; v_exp[1] = '{4'hB, 3'd5, 1'b1, 1'b0};
        v_cw[2] = 8'hAB; v_exp[2] = '{4'hB, 3'd0, 1'b1, 1'b0};
        v_cw[3] = 8'hAC; v_exp[3] = '{4'hB, 3'd3, 1'b0, 1'b1};
        v_cw[4] = 8'h00; v_exp[4] = '{4'h0, 3'd0, 1'b0, 1'b0};
        v_cw[5] = 8'hFF; v_exp[5] = '{4'hF, 3'd0, 1'b0, 1'b0};
        v_cw[6] = 8'h02; v_exp[6] = '{4'h0, 3'd1, 1'b1, 1'b0};
        v_cw[7] = 8'h7F; v_exp[7] = '{4'hF, 3'd7, 1'b1, 1'b0};
        v_cw[8] = 8'h03; v_exp[8] = '{4'h0, 3'd1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_cw = 8'h00; out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outputs", {23'd0, out_data, out_syndrome, out_sec, out_ded}, 32'd0);
        check("rst_corr", 32'(corr_cnt), 32'd0);
        check("rst_uncorr", 32'(uncorr_cnt), 32'd0);

        // Clean word latency: valid two cycles after presentation.
        out_ready = 1'b1;
        send(v_cw[0], v_exp[0], st);
        idle();
        @(negedge clk);
        check("lat_one_cycle", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_two_cycle", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 1; i < 4; i++) begin
            send(v_cw[i], v_exp[i], st);
            idle();
            drain();
            check_cnts($sformatf("single_%0d", i));
        end

        // Back-to-back burst must never stall with out_ready high.
        tot = 0;
        for (int i = 0; i < 9; i++) begin
            send(v_cw[i], v_exp[i], st);
            tot += st;
        end
        idle();
        check("burst_stalls", 32'(tot), 32'd0);
        drain();
        check_cnts("burst");

        // Back-pressure: two words buffered, third held off, outputs frozen.
        out_ready = 1'b0;
        send(v_cw[0], v_exp[0], st);
        send(v_cw[1], v_exp[1], st);
        in_valid = 1'b1;
        in_cw    = v_cw[3];
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", {22'd0, out_valid, out_data, out_syndrome, out_sec, out_ded},
                  {22'd0, 1'b1, 4'hB, 3'd0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(v_cw[3], v_exp[3], st);
        idle();
        drain();
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Saturation of the correction counter.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        check_cnts("clr");
        for (int i = 0; i < 255; i++) send(v_cw[1], v_exp[1], st);
        idle();
        drain();
        check("sat_reach", 32'(corr_cnt), exp_cnt(255));
        send(v_cw[1], v_exp[1], st);
        idle();
        drain();
        check("sat_hold", 32'(corr_cnt), exp_cnt(255));

        // Clear held across an error handshake wins.
        cnt_clr = 1'b1;
        send(v_cw[3], v_exp[3], st);
        idle();
        drain();
        cnt_clr = 1'b0;
        check("clr_wins_corr", 32'(corr_cnt), 32'd0);
        check("clr_wins_uncorr", 32'(uncorr_cnt), 32'd0);

        // Asynchronous reset with words in flight.
        send(v_cw[1], v_exp[1], st);
        idle();
        drain();
        out_ready = 1'b0;
        send(v_cw[0], v_exp[0], st);
        send(v_cw[2], v_exp[2], st);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_corr", 32'(corr_cnt), 32'd0);
        check("midrst_uncorr", 32'(uncorr_cnt), 32'd0);
        sb.delete();
        m_corr   = 0;
        m_uncorr = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_empty", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(v_cw[2], v_exp[2], st);
        idle();
        drain();
        check_cnts("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
